// File: rtl/modn_counter.sv
// -----------------------------------------------------------------------------
// modn_counter
//
// Parametrised modulo-N counter with a runtime modulus, up/down direction,
// count enable, synchronous load, a combinational terminal-count strobe for
// chaining, and a saturating wrap-event counter.
//
// Optional feature macro: MODN_CNT_PRESCALE_EN
//   When defined, an internal prescaler counts enabled cycles and only every
//   PRESCALE-th enabled cycle performs a count step. When undefined, every
//   enabled cycle is a step cycle and PRESCALE is ignored.
//
// Parameters:
//   WIDTH    - count register width; legal modulus 1..2^WIDTH-1
//   WRAP_W   - width of the saturating wrap-event counter
//   PRESCALE - enabled cycles per count step (prescaler build only, >= 1)
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous, active-high reset
//   en       - count enable
//   up_dn    - 1 = count up, 0 = count down
//   load     - synchronous load of load_val (clamped to N-1)
//   load_val - value to load
//   mod_val  - runtime modulus N; count range 0..N-1
//   clr_wrap - synchronous clear of wrap_cnt
//   count    - registered count
//   tc       - terminal-count strobe, high in step cycles that wrap
//   wrap_cnt - saturating number of wraps since reset or clear
// -----------------------------------------------------------------------------
module modn_counter #(
    parameter int WIDTH    = 3,
    parameter int WRAP_W   = 8,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  mod_val,
    input  logic              clr_wrap,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam int               PS_LAST = (PRESCALE > 1) ? PRESCALE - 1 : 0;

    // Saturating increment for the wrap-event counter.
    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (&v) ? v : v + WRAP_W'(1);
    endfunction

    // Clamp a load value into 0..N-1; N of 0 or 1 forces 0.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v,
                                                    input logic [WIDTH-1:0] last,
                                                    input logic             degen);
        if (degen)
            return '0;
        return (v > last) ? last : v;
    endfunction

    logic [WIDTH-1:0] last_val;    // N-1, only meaningful when N >= 2
    logic             degen;       // N is 0 or 1
    logic             presc_done;  // prescaler allows a step this cycle
    logic             step;
    logic             wrap;        // the step (if taken) would wrap
    logic [WIDTH-1:0] step_val;

    // N-1 wraps to all-ones for N=0; degen guards every use of last_val.
    assign last_val = mod_val - ONE;
    assign degen    = (mod_val <= ONE);

`ifdef MODN_CNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;

    assign presc_done = (presc == PW'(PS_LAST));

    always_ff @(posedge clk) begin
        if (rst || load)
            presc <= '0;
        else if (en)
            presc <= presc_done ? '0 : presc + PW'(1);
    end
`else
    // No prescaler: every enabled cycle is a step cycle.
    assign presc_done = (PS_LAST >= 0);
`endif

    assign step = en && !load && !rst && presc_done;

    always_comb begin
        step_val = count;
        wrap     = 1'b0;
        if (degen) begin
            step_val = '0;
            wrap     = 1'b1;
        end else if (up_dn) begin
            // ">=" also catches a count left above N-1 by a lowered modulus.
            if (count >= last_val) begin
                step_val = '0;
                wrap     = 1'b1;
            end else begin
                step_val = count + ONE;
            end
        end else begin
            if (count == '0) begin
                step_val = last_val;
                wrap     = 1'b1;
            end else if (count > last_val) begin
                // Out of range after a modulus change: snap to top, no wrap.
                step_val = last_val;
            end else begin
                step_val = count - ONE;
            end
        end
    end

    assign tc = step && wrap;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= clamp_load(load_val, last_val, degen);
        else if (step)
            count <= step_val;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_wrap)
            wrap_cnt <= '0;
        else if (tc)
            wrap_cnt <= sat_inc(wrap_cnt);
    end

endmodule

// File: tb/tb_modn_counter.sv
// -----------------------------------------------------------------------------
// tb_modn_counter
//
// Self-checking bench for modn_counter (WIDTH=3, WRAP_W=2). Directed steps
// cover the main behaviours; a randomized phase is checked cycle by cycle
// against an integer reference model of the counting rules.
// -----------------------------------------------------------------------------
module tb_modn_counter;

    localparam int WIDTH  = 3;
    localparam int WRAP_W = 2;
`ifdef MODN_CNT_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif
    localparam int WMAX = (1 << WRAP_W) - 1;

    logic              clk;
    logic              rst;
    logic              en;
    logic              up_dn;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  mod_val;
    logic              clr_wrap;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_count;
    int m_wrap;
    int m_ps;

    modn_counter #(
        .WIDTH   (WIDTH),
        .WRAP_W  (WRAP_W),
        .PRESCALE(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .mod_val (mod_val),
        .clr_wrap(clr_wrap),
        .count   (count),
        .tc      (tc),
        .wrap_cnt(wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven: checks the
    // DUT against the model, then advances both across one rising edge.
    task automatic run_cycle();
        int  n;
        int  nxt;
        int  nw;
        int  nps;
        bit  stp;
        bit  wrp;
        #1;
        n   = int'(mod_val);
        stp = !rst && en && !load && (m_ps == PS - 1);
        wrp = 1'b0;
        nxt = m_count;
        if (rst) begin
            nxt = 0;
        end else if (load) begin
            if (n <= 1)                  nxt = 0;
            else if (int'(load_val) > n - 1) nxt = n - 1;
            else                         nxt = int'(load_val);
        end else if (stp) begin
            if (n <= 1) begin
                nxt = 0; wrp = 1'b1;
            end else if (up_dn) begin
                if (m_count >= n - 1) begin nxt = 0; wrp = 1'b1; end
                else nxt = m_count + 1;
            end else begin
                if (m_count == 0)         begin nxt = n - 1; wrp = 1'b1; end
                else if (m_count > n - 1) nxt = n - 1;
                else                      nxt = m_count - 1;
            end
        end
        if (rst || clr_wrap) nw = 0;
        else if (wrp)        nw = (m_wrap < WMAX) ? m_wrap + 1 : WMAX;
        else                 nw = m_wrap;
        if (rst || load) nps = 0;
        else if (en)     nps = (m_ps == PS - 1) ? 0 : m_ps + 1;
        else             nps = m_ps;

        chk("model_tc", 32'(tc), 32'(wrp));
        chk("model_count", 32'(count), 32'(m_count));
        chk("model_wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));

        @(posedge clk);
        m_count = nxt;
        m_wrap  = nw;
        m_ps    = nps;
        @(negedge clk);
    endtask

    initial begin
        int down_seq [7] = '{0, 4, 3, 2, 1, 0, 4};
        int nen;
        rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0;
        load_val = '0; mod_val = 3'd5; clr_wrap = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_count = 0; m_wrap = 0; m_ps = 0;

        // Reset state, with en=1 to confirm tc is gated by rst
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
        chk("rst_tc", 32'(tc), 0);
        run_cycle();
        rst = 1'b0;

`ifndef MODN_CNT_PRESCALE_EN
        // Up count mod 5
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("up_count", 32'(count), 32'(i % 5));
            chk("up_tc", 32'(tc), 32'(i % 5 == 4));
            if (i == 10) chk("up_wrap_after_10", 32'(wrap_cnt), 2);
            run_cycle();
        end

        // Down count mod 5 from 0
        load = 1'b1; load_val = '0;
        run_cycle();
        load = 1'b0; up_dn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("down_count", 32'(count), 32'(down_seq[i]));
            chk("down_tc", 32'(tc), 32'(down_seq[i] == 0));
            run_cycle();
        end

        // Load clamp, load beats step
        up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 3'd6; mod_val = 3'd5;
        #1;
        chk("load_tc", 32'(tc), 0);
        run_cycle();
        load = 1'b0; en = 1'b0;
        #1;
        chk("load_clamp_count", 32'(count), 4);

        // Modulus lowered, step up
        mod_val = 3'd7; load = 1'b1; load_val = 3'd6;
        run_cycle();
        load = 1'b0; mod_val = 3'd3; up_dn = 1'b1; en = 1'b1;
        #1;
        chk("modchg_up_tc", 32'(tc), 1);
        run_cycle();
        en = 1'b0;
        #1;
        chk("modchg_up_count", 32'(count), 0);

        // Modulus lowered, step down
        mod_val = 3'd7; load = 1'b1; load_val = 3'd6;
        run_cycle();
        load = 1'b0; mod_val = 3'd3; up_dn = 1'b0; en = 1'b1;
        #1;
        chk("modchg_dn_tc", 32'(tc), 0);
        run_cycle();
        en = 1'b0;
        #1;
        chk("modchg_dn_count", 32'(count), 2);

        // Modulus 1: held at 0, every enabled cycle wraps
        mod_val = 3'd1; en = 1'b1;
        run_cycle();
        for (int i = 0; i < 6; i++) begin
            en    = 1'($urandom_range(0, 1));
            up_dn = 1'($urandom_range(0, 1));
            #1;
            chk("mod1_count", 32'(count), 0);
            chk("mod1_tc", 32'(tc), 32'(en));
            run_cycle();
        end

        // Wrap saturation and clear-over-increment
        en = 1'b0; clr_wrap = 1'b1;
        run_cycle();
        clr_wrap = 1'b0; en = 1'b1;
        repeat (5) run_cycle();
        #1;
        chk("wrap_saturated", 32'(wrap_cnt), 3);
        clr_wrap = 1'b1;
        #1;
        chk("clr_with_wrap_tc", 32'(tc), 1);
        run_cycle();
        clr_wrap = 1'b0; en = 1'b0;
        #1;
        chk("clr_with_wrap", 32'(wrap_cnt), 0);

        // Reset mid-operation beats load and en
        en = 1'b1;
        repeat (2) run_cycle();
        en = 1'b0; mod_val = 3'd5; load = 1'b1; load_val = 3'd3;
        run_cycle();
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 3'd2;
        #1;
        chk("rst_mid_tc", 32'(tc), 0);
        run_cycle();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        #1;
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_wrap_cnt", 32'(wrap_cnt), 0);
`else
        // Prescaled up count mod 5 with a 3-cycle enable gap
        nen = 0; mod_val = 3'd5; up_dn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            en = !(i >= 6 && i < 9);
            #1;
            chk("ps_count", 32'(count), 32'((nen / 4) % 5));
            chk("ps_tc", 32'(tc), 32'(en && (nen % 4 == 3) && ((nen / 4) % 5 == 4)));
            run_cycle();
            if (en) nen++;
        end
`endif

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom_range(0, 1));
            load_val = 3'($urandom_range(0, 7));
            clr_wrap = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0)
                mod_val = 3'($urandom_range(0, 7));
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modn_counter.md
Name: modn_counter

Overview:
Parametrised modulo-N counter. It is the general successor to the fixed mod-5 counter used across the design.
- Modulus is set at runtime; direction, enable and synchronous load are selectable.
- A terminal-count strobe allows chaining instances into multi-digit counters.
- A saturating wrap counter supports event and period statistics.

Parameters:
- WIDTH, 3, count register width in bits; the legal modulus is 1..2^WIDTH-1.
- WRAP_W, 8, width of the saturating wrap-event counter.
- PRESCALE, 4, enabled cycles per count step. Used only when MODN_CNT_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, count enable; a step is allowed in a cycle only when en=1.
- up_dn, input, 1, direction: 1 = count up, 0 = count down.
- load, input, 1, synchronous load of load_val.
- load_val, input, WIDTH, value to load.
- mod_val, input, WIDTH, runtime modulus N; the count range is 0..N-1.
- clr_wrap, input, 1, synchronous clear of wrap_cnt.
- count, output, WIDTH, current count (registered).
- tc, output, 1, terminal-count strobe (combinational), usable as en of the next stage.
- wrap_cnt, output, WRAP_W, number of wraps since reset or clear, saturating.

Behaviour:
- Reset values: count=0, wrap_cnt=0, prescaler=0. tc=0 while rst=1.
- Priority each cycle: rst > load > step > hold.
- Load: count <= min(load_val, N-1); for N<=1 the loaded value is 0. Load resets the prescaler. A load is not a wrap: tc=0, wrap_cnt unchanged.
- Step cycle: en=1, load=0, rst=0, and (with prescale) prescaler at PRESCALE-1.
- Up step:
  - if count >= N-1 (including count > N-1 after mod_val was lowered): count <= 0, wrap;
  - else count <= count+1.
- Down step:
  - if count == 0: count <= N-1, wrap;
  - else if count > N-1: count <= N-1, no wrap;
  - else count <= count-1.
- N=0 or N=1: count is held at 0 and every step is a wrap.
- tc = 1 in exactly the step cycles that wrap. Depends combinationally on count, en, up_dn, mod_val, load, rst and the prescaler; no registered latency.
- Wrap: wrap_cnt <= wrap_cnt+1, saturating at all-ones.
- clr_wrap=1 sets wrap_cnt <= 0 and takes priority over an increment in the same cycle.
- Latency: count reflects a step or load one cycle after the enabling edge.
- Changing mod_val mid-run takes effect on the next step; the out-of-range rules above apply.
- Toggling up_dn between steps is legal; the next step uses the new direction.
- rst asserted mid-operation: all state returns to reset values on that edge, regardless of load or en.
- Full-width arithmetic, no overflow beyond WIDTH bits: N-1 is computed in WIDTH bits, and the compare is guarded for N=0.

Optional Feature:
- Macro: MODN_CNT_PRESCALE_EN.
- Defined: an internal prescaler of width clog2(PRESCALE) (min 1) counts en=1 cycles 0..PRESCALE-1.
  - Only the cycle where prescaler==PRESCALE-1 and en=1 is a step cycle; the prescaler then returns to 0.
  - en=0 holds the prescaler.
  - rst and load clear the prescaler.
  - tc is only possible in step cycles.
- Not defined: no prescaler logic exists, every en=1 cycle is a step cycle, and PRESCALE is ignored.

Test Plan:
- Up count (WIDTH=3, mod_val=5, up_dn=1, en=1, macro undefined):
  - stimulus: 12 cycles after reset;
  - required: count 0,1,2,3,4,0,1,...;
  - required: tc=1 in the cycles where count=4;
  - required: wrap_cnt=2 after 10 steps.
- Down count (mod_val=5, up_dn=0, starting from 0):
  - required: count 0,4,3,2,1,0,4;
  - required: tc=1 in the cycles where count=0.
- Load clamp and priority:
  - load=1, load_val=6, mod_val=5 -> count=4 next cycle, tc=0;
  - load=1 with en=1 in the same cycle -> load wins.
- Modulus change mid-run:
  - count=6 with mod_val=7; change mod_val to 3 and step up -> count=0, tc=1;
  - same setup but step down -> count=2, tc=0;
  - mod_val=1 -> count stays 0, tc=en every cycle.
- Wrap saturation and reset (WRAP_W=2):
  - 5 wraps -> wrap_cnt=3 (saturated);
  - clr_wrap asserted together with a wrap -> wrap_cnt=0;
  - rst asserted with count=3, en=1, load=1 -> count=0, wrap_cnt=0, tc=0.
- Prescale (macro defined, PRESCALE=4, mod_val=5, up):
  - count advances once every 4 en cycles; tc only on the 4th en cycle while count=4;
  - en low for 3 cycles in the middle -> step timing shifts by exactly 3 cycles.
